// File: rtl/vga_sync_decoder.sv
// VGA receive-side timing decoder: recovers pixel position from HSync/VSync,
// measures line/frame geometry and declares lock after consecutive clean frames.
module vga_sync_decoder #(
    parameter int H_TOTAL     = 800,
    parameter int H_ACT_START = 144,
    parameter int H_ACT       = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_ACT_START = 35,
    parameter int V_ACT       = 480,
    parameter int LOCK_FRAMES = 2,
    parameter int SYNC_POL    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [3:0]  red_in,
    input  logic [3:0]  green_in,
    input  logic [3:0]  blue_in,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        de,
    output logic [11:0] pix_rgb,
    output logic        line_start,
    output logic        frame_start,
    output logic        locked,
    output logic        h_err,
    output logic        v_err,
    output logic [11:0] h_meas,
    output logic [10:0] v_meas
);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_MEASURE,
        ST_LOCKED
    } state_t;

    localparam logic        SYNC_ACT = (SYNC_POL != 0);
    localparam logic [12:0] H_TOT13  = 13'(H_TOTAL);
    localparam logic [11:0] H_MISS   = 12'(H_TOTAL + 1);
    localparam logic [11:0] H_A0     = 12'(H_ACT_START);
    localparam logic [11:0] H_A1     = 12'(H_ACT_START + H_ACT);
    localparam logic [11:0] V_TOT12  = 12'(V_TOTAL);
    localparam logic [10:0] V_A0     = 11'(V_ACT_START);
    localparam logic [10:0] V_A1     = 11'(V_ACT_START + V_ACT);
    localparam logic [7:0]  GOOD_LIM = 8'(LOCK_FRAMES);

    state_t      state_q, state_d;
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic        hs_prev_q, hs_prev_d;
    logic        vs_prev_q, vs_prev_d;
    logic        seen_h_q, seen_h_d;
    logic        seen_v_q, seen_v_d;
    logic [7:0]  good_cnt_q, good_cnt_d;
    logic        frame_err_q, frame_err_d;

    logic [9:0]  pix_x_q, pix_x_d;
    logic [9:0]  pix_y_q, pix_y_d;
    logic        de_q, de_d;
    logic [11:0] pix_rgb_q, pix_rgb_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic        locked_q, locked_d;
    logic        h_err_q, h_err_d;
    logic        v_err_q, v_err_d;
    logic [11:0] h_meas_q, h_meas_d;
    logic [10:0] v_meas_q, v_meas_d;

    logic        hs_edge, vs_edge, any_err;
    logic [12:0] h_inc;
    logic [11:0] v_inc;

    assign hs_edge = (hsync_in == SYNC_ACT) && (hs_prev_q != SYNC_ACT);
    assign vs_edge = (vsync_in == SYNC_ACT) && (vs_prev_q != SYNC_ACT);

    always_comb begin
        state_d       = state_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        hs_prev_d     = hsync_in;
        vs_prev_d     = vsync_in;
        seen_h_d      = seen_h_q;
        seen_v_d      = seen_v_q;
        good_cnt_d    = good_cnt_q;
        frame_err_d   = frame_err_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        h_err_d       = 1'b0;
        v_err_d       = 1'b0;
        h_meas_d      = h_meas_q;
        v_meas_d      = v_meas_q;
        h_inc         = {1'b0, h_cnt_q} + 13'd1;
        v_inc         = {1'b0, v_cnt_q} + 12'd1;

        if (hs_edge) begin
            h_cnt_d      = '0;
            line_start_d = 1'b1;
            seen_h_d     = 1'b1;
            if (seen_h_q) begin
                h_meas_d = h_inc[11:0];
                h_err_d  = (h_inc != H_TOT13);
            end
        end else begin
            if (h_cnt_q != '1) begin
                h_cnt_d = h_inc[11:0];
            end
            // Missing HSync: flag once as the count first reaches the nominal length.
            if (seen_h_q && (h_inc == H_TOT13)) begin
                h_err_d  = 1'b1;
                h_meas_d = H_MISS;
            end
        end

        if (vs_edge) begin
            v_cnt_d       = '0;
            frame_start_d = 1'b1;
            seen_v_d      = 1'b1;
            if (seen_v_q) begin
                v_meas_d = v_inc[10:0];
                v_err_d  = (v_inc != V_TOT12);
            end
        end else if (hs_edge) begin
            if (v_cnt_q != '1) begin
                v_cnt_d = v_inc[10:0];
            end
            if (seen_v_q && (v_inc == V_TOT12)) begin
                v_err_d = 1'b1;
            end
        end

        any_err = h_err_d | v_err_d;

        case (state_q)
            ST_SEARCH: begin
                if (vs_edge) begin
                    state_d     = ST_MEASURE;
                    good_cnt_d  = '0;
                    frame_err_d = 1'b0;
                end
            end
            ST_MEASURE: begin
                if (vs_edge) begin
                    frame_err_d = 1'b0;
                    if (frame_err_q || any_err) begin
                        good_cnt_d = '0;
                    end else begin
                        good_cnt_d = good_cnt_q + 8'd1;
                        if (good_cnt_d >= GOOD_LIM) begin
                            state_d = ST_LOCKED;
                        end
                    end
                end else if (any_err) begin
                    frame_err_d = 1'b1;
                    good_cnt_d  = '0;
                end
            end
            ST_LOCKED: begin
                if (any_err) begin
                    state_d    = ST_SEARCH;
                    good_cnt_d = '0;
                end
            end
            default: state_d = ST_SEARCH;
        endcase

        // Outputs follow the post-update state so an error drops lock and de on its own cycle.
        locked_d  = (state_d == ST_LOCKED);
        de_d      = locked_d && (h_cnt_d >= H_A0) && (h_cnt_d < H_A1)
                             && (v_cnt_d >= V_A0) && (v_cnt_d < V_A1);
        pix_x_d   = de_d ? 10'(h_cnt_d - H_A0) : '0;
        pix_y_d   = de_d ? 10'(v_cnt_d - V_A0) : '0;
        pix_rgb_d = de_d ? {red_in, green_in, blue_in} : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_SEARCH;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hs_prev_q     <= ~SYNC_ACT;
            vs_prev_q     <= ~SYNC_ACT;
            seen_h_q      <= 1'b0;
            seen_v_q      <= 1'b0;
            good_cnt_q    <= '0;
            frame_err_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            de_q          <= 1'b0;
            pix_rgb_q     <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            h_err_q       <= 1'b0;
            v_err_q       <= 1'b0;
            h_meas_q      <= '0;
            v_meas_q      <= '0;
        end else if (pix_en) begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            seen_h_q      <= seen_h_d;
            seen_v_q      <= seen_v_d;
            good_cnt_q    <= good_cnt_d;
            frame_err_q   <= frame_err_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            de_q          <= de_d;
            pix_rgb_q     <= pix_rgb_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            h_err_q       <= h_err_d;
            v_err_q       <= v_err_d;
            h_meas_q      <= h_meas_d;
            v_meas_q      <= v_meas_d;
        end
    end

    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign de          = de_q;
    assign pix_rgb     = pix_rgb_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign h_err       = h_err_q;
    assign v_err       = v_err_q;
    assign h_meas      = h_meas_q;
    assign v_meas      = v_meas_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a scaled-down raster (20x12 samples,
// 10x6 active at offset 4,3) so whole frames fit in a short run.
module tb_vga_sync_decoder;

    localparam int HT   = 20;
    localparam int HAS  = 4;
    localparam int HA   = 10;
    localparam int VT   = 12;
    localparam int VAS  = 3;
    localparam int VA   = 6;
    localparam int HS_W = 2;
    localparam int VS_W = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_en;
    logic        hsync_in, vsync_in;
    logic [3:0]  red_in, green_in, blue_in;
    logic [9:0]  pix_x, pix_y;
    logic        de;
    logic [11:0] pix_rgb;
    logic        line_start, frame_start, locked, h_err, v_err;
    logic [11:0] h_meas;
    logic [10:0] v_meas;

    always #5 clk = ~clk;

    vga_sync_decoder #(
        .H_TOTAL     (HT),
        .H_ACT_START (HAS),
        .H_ACT       (HA),
        .V_TOTAL     (VT),
        .V_ACT_START (VAS),
        .V_ACT       (VA),
        .LOCK_FRAMES (2),
        .SYNC_POL    (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_en      (pix_en),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .red_in      (red_in),
        .green_in    (green_in),
        .blue_in     (blue_in),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .de          (de),
        .pix_rgb     (pix_rgb),
        .line_start  (line_start),
        .frame_start (frame_start),
        .locked      (locked),
        .h_err       (h_err),
        .v_err       (v_err),
        .h_meas      (h_meas),
        .v_meas      (v_meas)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int herr_cnt, verr_cnt, ls_cnt, fs_cnt, de_cnt, pix_bad;
    int herr_meas, herr_locked, herr_de, verr_meas, verr_locked;
    int first_l, first_h, first_x, first_y, last_x, last_y;
    bit got_first;
    int vs_edges, lock_edge;
    bit lk_prev;
    bit chk_px;
    int short_line = -1;
    int freeze_l   = -1;
    int rst_l      = -1;
    int rst_h      = -1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] patt(input int l, input int h);
        return {4'(h), 4'(l), 4'h5};
    endfunction

    function automatic logic [60:0] out_vec();
        return {pix_x, pix_y, de, pix_rgb, line_start, frame_start, locked,
                h_err, v_err, h_meas, v_meas};
    endfunction

    task automatic clear_stats();
        herr_cnt = 0; verr_cnt = 0; ls_cnt = 0; fs_cnt = 0; de_cnt = 0; pix_bad = 0;
        herr_meas = -1; herr_locked = -1; herr_de = -1; verr_meas = -1; verr_locked = -1;
        first_l = -1; first_h = -1; first_x = -1; first_y = -1; last_x = -1; last_y = -1;
        got_first = 1'b0;
    endtask

    // One pixel sample: drive on a falling edge with pix_en high for one clock,
    // then an idle clock; outputs are inspected on the following falling edge.
    task automatic step(input logic hs, input logic vs, input logic [11:0] rgb,
                        input int l, input int h);
        bit exp_de;
        @(negedge clk);
        hsync_in = hs;
        vsync_in = vs;
        {red_in, green_in, blue_in} = rgb;
        pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
        if (h_err) begin
            herr_cnt++; herr_meas = int'(h_meas); herr_locked = int'(locked); herr_de = int'(de);
        end
        if (v_err) begin
            verr_cnt++; verr_meas = int'(v_meas); verr_locked = int'(locked);
        end
        if (line_start)  ls_cnt++;
        if (frame_start) fs_cnt++;
        if (locked && !lk_prev) lock_edge = vs_edges;
        lk_prev = locked;
        if (chk_px) begin
            exp_de = (h >= HAS) && (h < HAS + HA) && (l >= VAS) && (l < VAS + VA);
            if (exp_de) begin
                if (de !== 1'b1 || pix_x !== 10'(h - HAS) || pix_y !== 10'(l - VAS) || pix_rgb !== rgb)
                    pix_bad++;
            end else if (de !== 1'b0 || pix_x !== '0 || pix_y !== '0 || pix_rgb !== '0) begin
                pix_bad++;
            end
        end
        if (de) begin
            de_cnt++;
            if (!got_first) begin
                got_first = 1'b1;
                first_l = l; first_h = h; first_x = int'(pix_x); first_y = int'(pix_y);
            end
            last_x = int'(pix_x);
            last_y = int'(pix_y);
        end
    endtask

    task automatic freeze_test();
        logic [60:0] exp_v;
        exp_v = {10'd0, 10'd0, 1'b0, 12'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'(HT), 11'(VT)};
        check_val("freeze_pre", 64'(out_vec()), 64'(exp_v));
        repeat (100) begin
            @(negedge clk);
            hsync_in = ~hsync_in;
            vsync_in = ~vsync_in;
            {red_in, green_in, blue_in} = 12'($urandom);
        end
        check_val("freeze_post", 64'(out_vec()), 64'(exp_v));
    endtask

    task automatic reset_test();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_val("async_rst", 64'(out_vec()), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        vs_edges = 0; lock_edge = 0; lk_prev = 1'b0;
        herr_cnt = 0; verr_cnt = 0;
    endtask

    task automatic send_frame(input int nlines);
        for (int l = 0; l < nlines; l++) begin
            int len;
            len = (l == short_line) ? HT - 1 : HT;
            for (int h = 0; h < len; h++) begin
                if (l == 0 && h == 0) vs_edges++;
                step(h < HS_W, l < VS_W, patt(l, h), l, h);
                if (l == freeze_l && h == 0) freeze_test();
                if (l == rst_l && h == rst_h) reset_test();
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; pix_en = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        {red_in, green_in, blue_in} = 12'hFFF;
        chk_px = 1'b0; lk_prev = 1'b0; vs_edges = 0; lock_edge = 0;
        clear_stats();
        repeat (3) @(negedge clk);
        check_val("reset_outputs", 64'(out_vec()), 64'd0);
        rst_n = 1'b1;

        // Acquisition and one fully locked frame
        send_frame(VT);
        send_frame(VT);
        clear_stats();
        chk_px = 1'b1;
        send_frame(VT);
        chk_px = 1'b0;
        check_val("lock_edge", 64'(lock_edge), 64'd3);
        check_val("de_count", 64'(de_cnt), 64'(HA * VA));
        check_val("first_de_h", 64'(first_h), 64'(HAS));
        check_val("first_de_l", 64'(first_l), 64'(VAS));
        check_val("first_x", 64'(first_x), 64'd0);
        check_val("first_y", 64'(first_y), 64'd0);
        check_val("last_x", 64'(last_x), 64'(HA - 1));
        check_val("last_y", 64'(last_y), 64'(VA - 1));
        check_val("pix_bad", 64'(pix_bad), 64'd0);
        check_val("nom_herr", 64'(herr_cnt), 64'd0);
        check_val("nom_verr", 64'(verr_cnt), 64'd0);
        check_val("h_meas", 64'(h_meas), 64'(HT));
        check_val("v_meas", 64'(v_meas), 64'(VT));
        check_val("line_starts", 64'(ls_cnt), 64'(VT));
        check_val("frame_starts", 64'(fs_cnt), 64'd1);

        // One short line while locked, then relock
        clear_stats();
        short_line = 5;
        send_frame(VT);
        short_line = -1;
        vs_edges = 0; lock_edge = 0;
        send_frame(VT);
        send_frame(VT);
        send_frame(VT);
        check_val("short_herr_cnt", 64'(herr_cnt), 64'd1);
        check_val("short_hmeas", 64'(herr_meas), 64'(HT - 1));
        check_val("short_locked", 64'(herr_locked), 64'd0);
        check_val("short_de", 64'(herr_de), 64'd0);
        check_val("short_verr", 64'(verr_cnt), 64'd0);
        check_val("short_relock_edge", 64'(lock_edge), 64'd3);

        // HSync held inactive long enough for the counter to saturate
        clear_stats();
        for (int i = 0; i < 4200; i++) step(1'b0, 1'b0, 12'hFFF, -1, -1);
        check_val("miss_herr_cnt", 64'(herr_cnt), 64'd1);
        check_val("miss_hmeas", 64'(herr_meas), 64'(HT + 1));
        check_val("miss_locked", 64'(herr_locked), 64'd0);
        vs_edges = 0; lock_edge = 0;
        send_frame(VT);
        send_frame(VT);
        send_frame(VT);
        check_val("miss_relock_edge", 64'(lock_edge), 64'd3);

        // One short frame while locked
        clear_stats();
        send_frame(VT - 1);
        send_frame(VT);
        check_val("vshort_verr_cnt", 64'(verr_cnt), 64'd1);
        check_val("vshort_vmeas", 64'(verr_meas), 64'(VT - 1));
        check_val("vshort_locked", 64'(verr_locked), 64'd0);
        check_val("vshort_herr", 64'(herr_cnt), 64'd0);
        send_frame(VT);
        send_frame(VT);
        send_frame(VT);
        check_val("vshort_relock", 64'(locked), 64'd1);

        // pix_en held low mid-frame
        clear_stats();
        chk_px = 1'b1;
        freeze_l = 4;
        send_frame(VT);
        freeze_l = -1;
        chk_px = 1'b0;
        check_val("freeze_herr", 64'(herr_cnt), 64'd0);
        check_val("freeze_de_count", 64'(de_cnt), 64'(HA * VA));
        check_val("freeze_pix_bad", 64'(pix_bad), 64'd0);
        check_val("freeze_hmeas", 64'(h_meas), 64'(HT));

        // Asynchronous reset mid-frame, then reacquire
        clear_stats();
        rst_l = 6; rst_h = 7;
        send_frame(VT);
        rst_l = -1; rst_h = -1;
        send_frame(VT);
        send_frame(VT);
        send_frame(VT);
        check_val("rst_relock_edge", 64'(lock_edge), 64'd3);
        check_val("rst_herr", 64'(herr_cnt), 64'd0);
        check_val("rst_verr", 64'(verr_cnt), 64'd0);
        check_val("rst_locked", 64'(locked), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
Receive-side counterpart of the VGA timing generator. Samples HSync/VSync/RGB at pixel rate and recovers horizontal/vertical position. Measures line length and frame height, and declares lock after consecutive conforming frames. Outputs pixel coordinates, data-enable and gated RGB for capture or on-board self-check of the 640x480 generator path.

Parameters:
H_TOTAL, 800, pixel samples per line
H_ACT_START, 144, first active sample index after the HSync active edge
H_ACT, 640, active pixels per line
V_TOTAL, 525, lines per frame
V_ACT_START, 35, first active line index after the VSync active edge
V_ACT, 480, active lines per frame
LOCK_FRAMES, 2, consecutive good frames required to lock
SYNC_POL, 1, active level of HSync/VSync (1 = active high)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
pix_en  in  1  pixel-rate enable; inputs are sampled only on clk edges with pix_en=1
hsync_in  in  1  horizontal sync
vsync_in  in  1  vertical sync
red_in  in  4  red
green_in  in  4  green
blue_in  in  4  blue
pix_x  out  10  active column 0..639; 0 when de=0
pix_y  out  10  active row 0..479; 0 when de=0
de  out  1  data enable
pix_rgb  out  12  {red,green,blue}; 0 when de=0
line_start  out  1  one-sample pulse on the HSync active edge
frame_start  out  1  one-sample pulse on the VSync active edge
locked  out  1  lock status
h_err  out  1  one-sample pulse on a line-length error
v_err  out  1  one-sample pulse on a frame-height error
h_meas  out  12  length of the last completed line
v_meas  out  11  height of the last completed frame

Behaviour:
- Reset: all outputs 0. State = SEARCH. Counters 0. Previous-sync registers = inactive. seen_h = seen_v = 0.
- Clock enable: all state advances only when pix_en=1. With pix_en=0 every register holds, including output pulses. Latency is one clk from the sampling edge to the outputs.
- Edge detection: active edge = sample is active (per SYNC_POL) and the previous sample was inactive.
- Horizontal counter h_cnt (12 bit):
  - On an HSync active edge: h_cnt <= 0, line_start=1.
  - If seen_h=1, also h_meas <= h_cnt+1.
  - If seen_h=1 and h_cnt+1 != H_TOTAL, h_err=1.
  - After the edge, seen_h <= 1.
  - Otherwise h_cnt increments and saturates at 4095.
  - If seen_h=1 and h_cnt reaches H_TOTAL with no edge (missing sync): h_err=1 once, h_meas <= H_TOTAL+1.
- Vertical counter v_cnt (11 bit): increments on each HSync active edge and saturates at 2047.
  - On a VSync active edge: v_cnt <= 0 and frame_start=1.
  - VSync and HSync edges coincide in normal timing; the VSync reset takes priority over the increment in the same sample.
  - If seen_v=1: v_meas <= v_cnt+1 (counting the coincident line). If v_meas != V_TOTAL, v_err=1.
  - After the edge, seen_v <= 1.
  - Missing VSync: v_err=1 once when v_cnt reaches V_TOTAL without a VSync edge.
- Lock FSM:
  - SEARCH -> MEASURE on the first VSync edge; good_cnt=0.
  - MEASURE: on each VSync edge that closes a frame with no h_err/v_err during it, good_cnt+1. Any error in the frame sets good_cnt=0.
  - MEASURE: when good_cnt reaches LOCK_FRAMES, -> LOCKED and locked=1 on the output cycle of that edge.
  - LOCKED: any h_err or v_err -> SEARCH, and locked=0 on the same output cycle as the error pulse. seen_h and seen_v are kept.
- de = locked AND H_ACT_START <= h_cnt < H_ACT_START+H_ACT AND V_ACT_START <= v_cnt < V_ACT_START+V_ACT.
- When de=1: pix_x = h_cnt-H_ACT_START, pix_y = v_cnt-V_ACT_START, pix_rgb = the sampled RGB.
- Sync inputs are used as given; metastability synchronisers are instantiated outside this block.

Test Plan:
- Nominal: 800x525 timing, pix_en every 2nd clk, active RGB=FFF.
  - locked rises on the 3rd VSync edge.
  - In the next frame, first de has pix_x=0, pix_y=0 at h_cnt=144, v_cnt=35.
  - Last de has pix_x=639, pix_y=479.
  - 307200 de samples per frame. h_meas=800, v_meas=525. No h_err/v_err.
- While locked, one 799-sample line: h_err pulse, h_meas=799, locked=0 and de=0 the same cycle; locked returns after 3 further clean VSync edges.
- HSync held inactive while locked: h_err exactly once when h_cnt=800; h_cnt saturates at 4095 with no further pulses.
- While locked, one 524-line frame: v_err pulse at its closing VSync edge, v_meas=524, lock lost.
- pix_en held low 100 clks mid-line: all outputs frozen, no error; h_meas=800 at the next line.
- rst_n asserted mid-frame (asynchronously, between clk edges): all outputs 0 immediately. After release, no h_err on the first HSync edge; relock after 3 VSync edges.
